o_buft_serial_driver: RTL and testbench

//  Serialises a parallel word onto a single tristated pad line. Produces the

---
 rtl/o_buft_serial_driver_if.sv | 23 ++
 rtl/o_buft_serial_driver.sv | 158 +++++++++++++++
 tb/tb_o_buft_serial_driver.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/o_buft_serial_driver_if.sv
// Handshake and pad-side signals of the O_BUFT serial driver.
// The master side supplies words; the slave side serialises them onto the pad.
interface o_buft_serial_driver_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             din;
  logic             out_tristate;
  logic             busy;
  logic             done;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, din, out_tristate, busy, done
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, din, out_tristate, busy, done
  );
endinterface

// File: rtl/o_buft_serial_driver.sv
// Serialises a parallel word MSB-first onto an O_BUFT (I = din, T = out_tristate),
// framing each word with lead-in, trail and released-gap windows.
module o_buft_serial_driver #(
  parameter int   WIDTH        = 8,
  parameter int   BIT_CYCLES   = 4,
  parameter int   LEAD_CYCLES  = 2,
  parameter int   TRAIL_CYCLES = 1,
  parameter int   GAP_CYCLES   = 2,
  parameter logic IDLE_LEVEL   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  o_buft_serial_driver_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_t;

  localparam int IDX_W = $clog2(WIDTH) + 1;

  localparam logic [7:0]       LEAD_LAST  = 8'(LEAD_CYCLES - 1);
  localparam logic [7:0]       BIT_LAST   = 8'(BIT_CYCLES - 1);
  localparam logic [7:0]       TRAIL_LAST = 8'(TRAIL_CYCLES - 1);
  localparam logic [7:0]       GAP_LAST   = 8'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(WIDTH - 1);

  // Zero-length windows are skipped by jumping straight to the next non-empty state.
  localparam state_t FIRST_ST   = (LEAD_CYCLES > 0) ? LEAD : SHIFT;
  localparam state_t POST_SHIFT = (TRAIL_CYCLES > 0) ? TRAIL :
                                  (GAP_CYCLES > 0)   ? GAP   : IDLE;
  localparam state_t POST_TRAIL = (GAP_CYCLES > 0) ? GAP : IDLE;
  localparam state_t FINAL_ST   = (GAP_CYCLES > 0)   ? GAP   :
                                  (TRAIL_CYCLES > 0) ? TRAIL : SHIFT;

  state_t           state, state_nx;
  logic [7:0]       cnt, cnt_nx;
  logic [IDX_W-1:0] idx, idx_nx;
  logic [WIDTH-1:0] sreg, sreg_nx;

  logic din_p0, drive_p0, ready_p0, busy_p0, done_p0;
  logic din_p1, drive_p1, ready_p1, busy_p1, done_p1;

  function automatic logic last_cycle(input state_t st, input logic [7:0] c,
                                      input logic [IDX_W-1:0] i);
    case (st)
      LEAD:    return c == LEAD_LAST;
      SHIFT:   return (c == BIT_LAST) && (i == IDX_LAST);
      TRAIL:   return c == TRAIL_LAST;
      GAP:     return c == GAP_LAST;
      default: return 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sreg  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
      sreg  <= sreg_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    sreg_nx  = sreg;
    case (state)
      IDLE: begin
        if (bus.tx_valid) begin
          state_nx = FIRST_ST;
          sreg_nx  = bus.tx_data;
          cnt_nx   = '0;
          idx_nx   = '0;
        end
      end
      LEAD: begin
        if (cnt == LEAD_LAST) begin
          state_nx = SHIFT;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      SHIFT: begin
        if (cnt == BIT_LAST) begin
          cnt_nx = '0;
          if (idx == IDX_LAST) begin
            state_nx = POST_SHIFT;
            idx_nx   = '0;
          end else begin
            idx_nx  = idx + IDX_W'(1);
            sreg_nx = sreg << 1;
          end
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      TRAIL: begin
        if (cnt == TRAIL_LAST) begin
          state_nx = POST_TRAIL;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
        idx_nx   = '0;
      end
    endcase
  end

  // p0 -> p1: outputs derived from the next state so pad data and enable switch together
  always_comb begin
    drive_p0 = (state_nx == LEAD) || (state_nx == SHIFT) || (state_nx == TRAIL);
    din_p0   = (state_nx == SHIFT) ? sreg_nx[WIDTH-1] : IDLE_LEVEL;
    ready_p0 = (state_nx == IDLE);
    busy_p0  = (state_nx != IDLE);
    done_p0  = (state_nx == FINAL_ST) && last_cycle(state_nx, cnt_nx, idx_nx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      din_p1   <= IDLE_LEVEL;
      drive_p1 <= 1'b0;
      ready_p1 <= 1'b1;
      busy_p1  <= 1'b0;
      done_p1  <= 1'b0;
    end else begin
      din_p1   <= din_p0;
      drive_p1 <= drive_p0;
      ready_p1 <= ready_p0;
      busy_p1  <= busy_p0;
      done_p1  <= done_p0;
    end
  end

  assign bus.din          = din_p1;
  assign bus.out_tristate = drive_p1;
  assign bus.tx_ready     = ready_p1;
  assign bus.busy         = busy_p1;
  assign bus.done         = done_p1;

endmodule

// File: tb/tb_o_buft_serial_driver.sv
// Bench for o_buft_serial_driver: default instance plus a minimal-timing 4-bit instance,
// checked against a cycle-list frame model built from the framing rules.
module tb_o_buft_serial_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  o_buft_serial_driver_if #(.WIDTH(8)) bus_a ();
  o_buft_serial_driver_if #(.WIDTH(4)) bus_b ();

  o_buft_serial_driver dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  o_buft_serial_driver #(
    .WIDTH(4), .BIT_CYCLES(1), .LEAD_CYCLES(0), .TRAIL_CYCLES(0), .GAP_CYCLES(0)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  logic cap_oe  [0:199];
  logic cap_din [0:199];

  typedef struct {
    logic [7:0] data;
    logic [7:0] exp_word;
    int         exp_len;
    int         exp_dones;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v, input logic [31:0] d);
    if (sel) begin
      bus_b.tx_valid = v;
      bus_b.tx_data  = d[3:0];
    end else begin
      bus_a.tx_valid = v;
      bus_a.tx_data  = d[7:0];
    end
  endtask

  // {out_tristate, din, done, tx_ready, busy}
  function automatic logic [4:0] outs(input bit sel);
    if (sel) return {bus_b.out_tristate, bus_b.din, bus_b.done, bus_b.tx_ready, bus_b.busy};
    return {bus_a.out_tristate, bus_a.din, bus_a.done, bus_a.tx_ready, bus_a.busy};
  endfunction

  // Default framing: 2 lead cycles, then 4 cycles per bit; sample mid-bit.
  function automatic logic [7:0] decode(input int s);
    logic [7:0] w;
    for (int k = 0; k < 8; k++) w[7-k] = cap_din[s + 2 + 4*k + 1];
    return w;
  endfunction

  task automatic wait_ready(input bit sel, input string name);
    logic [4:0] o;
    int n;
    o = outs(sel);
    n = 0;
    while (!o[1] && n < 100) begin
      @(negedge clk);
      o = outs(sel);
      n++;
    end
    if (!o[1]) chk({name, "_ready_timeout"}, 32'd0, 32'd1);
  endtask

  // Builds the expected per-cycle {oe,din} list from the frame rules and compares every cycle.
  task automatic check_frame(input bit sel, input logic [31:0] data, input int w, input int b,
                             input int lead, input int trail, input int gap,
                             input int inject, input string name);
    logic [1:0] exp_q[$];
    logic [4:0] o, e;
    int total;
    exp_q.delete();
    repeat (lead) exp_q.push_back(2'b11);
    for (int k = 0; k < w; k++) repeat (b) exp_q.push_back({1'b1, data[w-1-k]});
    repeat (trail) exp_q.push_back(2'b11);
    repeat (gap) exp_q.push_back(2'b01);
    total = exp_q.size();
    @(negedge clk);
    drive(sel, 1'b1, data);
    wait_ready(sel, name);
    for (int i = 0; i < total; i++) begin
      @(negedge clk);
      if (i == 0) drive(sel, 1'b0, $urandom);
      if (inject >= 0 && i == inject) drive(sel, 1'b1, 32'h12);
      if (inject >= 0 && i == inject + 1) drive(sel, 1'b0, 32'h12);
      o = outs(sel);
      e = {exp_q[i], (i == total - 1), 1'b0, 1'b1};
      chk($sformatf("%s_cyc%0d", name, i + 1), {27'd0, o}, {27'd0, e});
    end
    @(negedge clk);
    o = outs(sel);
    chk($sformatf("%s_ready_after_%0d", name, total + 1), {27'd0, o}, {27'd0, 5'b01010});
  endtask

  task automatic capture_frame(input logic [7:0] data, output int len, output int dones,
                               output logic [7:0] word);
    logic [4:0] o;
    int s;
    @(negedge clk);
    drive(0, 1'b1, {24'd0, data});
    wait_ready(0, "cap");
    len = -1;
    dones = 0;
    s = -1;
    for (int c = 1; c < 200; c++) begin
      @(negedge clk);
      if (c == 1) drive(0, 1'b0, {24'd0, ~data});
      o = outs(0);
      cap_oe[c]  = o[4];
      cap_din[c] = o[3];
      if (o[4] && s < 0) s = c;
      if (o[2]) dones++;
      if (o[1]) begin
        len = c;
        break;
      end
    end
    word = (s > 0 && s < 160) ? decode(s) : 8'hxx;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[5];
    logic [4:0] o;
    int         len, dones, s1, s2, released, oe_hits, done_cnt;
    logic [7:0] word;
    logic       prev_rdy;

    vecs[0] = '{8'hA5, 8'hA5, 38, 1};
    vecs[1] = '{8'h00, 8'h00, 38, 1};
    vecs[2] = '{8'hFF, 8'hFF, 38, 1};
    vecs[3] = '{8'h3C, 8'h3C, 38, 1};
    vecs[4] = '{8'h81, 8'h81, 38, 1};

    drive(0, 1'b0, 0);
    drive(1, 1'b0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state held with no requests
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("idle_a_%0d", i), {27'd0, outs(0)}, {27'd0, 5'b01010});
    end
    chk("idle_b", {27'd0, outs(1)}, {27'd0, 5'b01010});

    // Reference frame, cycle by cycle
    check_frame(0, 32'hA5, 8, 4, 2, 1, 2, -1, "a5");

    // Table: decoded word, accept-to-ready latency, done pulses
    foreach (vecs[v]) begin
      capture_frame(vecs[v].data, len, dones, word);
      chk($sformatf("tbl%0d_word", v), {24'd0, word}, {24'd0, vecs[v].exp_word});
      chk($sformatf("tbl%0d_len", v), len, vecs[v].exp_len);
      chk($sformatf("tbl%0d_done", v), dones, vecs[v].exp_dones);
    end

    // Back-to-back with tx_valid held high
    @(negedge clk);
    drive(0, 1'b1, 32'hFF);
    wait_ready(0, "b2b");
    prev_rdy = 1'b0;
    for (int c = 1; c < 90; c++) begin
      @(negedge clk);
      if (c == 1) drive(0, 1'b1, 32'h00);
      if (c > 1 && prev_rdy) drive(0, 1'b0, 32'h00);
      o = outs(0);
      cap_oe[c]  = o[4];
      cap_din[c] = o[3];
      prev_rdy   = o[1];
    end
    s1 = -1; s2 = -1; released = 0;
    for (int c = 1; c < 90; c++) begin
      if (s1 < 0 && cap_oe[c]) s1 = c;
      else if (s1 > 0 && s2 < 0 && !cap_oe[c]) released++;
      else if (s1 > 0 && s2 < 0 && released > 0 && cap_oe[c]) s2 = c;
    end
    chk("b2b_first_start", s1, 1);
    chk("b2b_released", released, 3);
    chk("b2b_word1", {24'd0, (s1 > 0 && s1 < 160) ? decode(s1) : 8'hxx}, 32'hFF);
    chk("b2b_word2", {24'd0, (s2 > 0 && s2 < 160) ? decode(s2) : 8'hxx}, 32'h00);

    // Reset pulse during SHIFT bit 3
    @(negedge clk);
    wait_ready(0, "rst_mid");
    drive(0, 1'b1, 32'hA5);
    done_cnt = 0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 1) drive(0, 1'b0, 32'h00);
      o = outs(0);
      if (o[2]) done_cnt++;
    end
    chk("rst_mid_driving", {31'd0, o[4]}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_released", {27'd0, outs(0)}, {27'd0, 5'b01010});
    oe_hits = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      o = outs(0);
      if (o[2]) done_cnt++;
      if (o[4]) oe_hits++;
    end
    chk("rst_mid_no_done", done_cnt, 0);
    chk("rst_mid_stays_off", oe_hits, 0);
    check_frame(0, 32'h3C, 8, 4, 2, 1, 2, -1, "after_rst");

    // Zero-length windows, one cycle per bit
    check_frame(1, 32'h9, 4, 1, 0, 0, 0, -1, "min_1001");

    // Request during SHIFT is ignored
    check_frame(0, 32'h80, 8, 4, 2, 1, 2, 10, "ignore");
    oe_hits = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (outs(0) & 5'b10000) oe_hits++;
    end
    chk("ignore_no_second_frame", oe_hits, 0);

    // Randomised frames on both instances
    for (int r = 0; r < 6; r++)
      check_frame(0, {24'd0, 8'($urandom)}, 8, 4, 2, 1, 2, -1, $sformatf("rnd_a%0d", r));
    for (int r = 0; r < 6; r++)
      check_frame(1, {28'd0, 4'($urandom)}, 4, 1, 0, 0, 0, -1, $sformatf("rnd_b%0d", r));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
